moore_step_arbiter: RTL and testbench
=====================================

// Module: moore_step_arbiter
// PURPOSE
//   Shares one Moore step engine (enable/a inputs, 3-state S0/S1/S2 cycle) among NREQ requesters.
//   A programmable prescaler sets the engine step rate. On each tick, a round-robin arbiter
//   grants one pending requester and drives that requester's 'a' bit into the engine for one step.
//   A shadow copy of the engine state supplies y to requesters without a readback path.
// PARAMETERS
//   NREQ   4   number of requesters (>=2)
//   DIV_W  8   width of prescaler divide value
// PORTS
//   clock       in   1      single clock, all logic on posedge
//   reset       in   1      synchronous, active-high
//   div         in   DIV_W  tick period minus 1 (0 = tick every cycle)
//   req         in   NREQ   per-requester step request, level, held until granted
//   req_a       in   NREQ   per-requester 'a' value, sampled on the tick cycle that grants it
//   gnt         out  NREQ   one-hot grant pulse, 1 cycle
//   eng_enable  out  1      engine step enable, 1-cycle pulse
//   eng_a       out  1      engine 'a' input, valid while eng_enable=1
//   eng_y       out  1      shadow engine output: 1 when shadow state is S1 or S2
// BEHAVIOUR
//   Reset (clock edge with reset=1):
//     cnt=0, ptr=0, gnt=0, eng_enable=0, eng_a=0, shadow=S0 (eng_y=0). Reset overrides everything.
//     A grant registered in the reset cycle is discarded.
//   Prescaler:
//     tick = (cnt==0). On tick, cnt<=div; otherwise cnt<=cnt-1.
//     div is sampled only at reload, so a change takes effect after the current period.
//     The first cycle after reset deasserts is a tick.
//     Ticks occur every div+1 cycles.
//   Arbitration (evaluated combinationally in the tick cycle T):
//     Winner k = first index with req[k]=1, searching ptr, ptr+1, ... modulo NREQ.
//     At edge T+1 (all outputs registered):
//       gnt=onehot(k), eng_enable=1, eng_a=req_a[k], ptr<=(k+1) mod NREQ.
//     At edge T+2: gnt=0, eng_enable=0, eng_a=0.
//     Tick with req=0: no grant, all outputs stay 0, ptr unchanged.
//     Non-tick cycles: no grant, regardless of req.
//   Requester rule:
//     Deassert req in the cycle gnt is seen.
//     If req is still 1 at the next tick, it is a new request at lowest priority (ptr moved past it).
//     Dropping req before the tick withdraws the request; no grant is issued for it.
//   Latency: request present at a tick -> gnt/eng_enable at +1 cycle.
//     Worst case wait = NREQ ticks.
//   Shadow FSM (tracks engine state; updates at the same edge the engine consumes eng_enable):
//     While eng_enable=1:
//       S0 -a-> S1, S1 -a-> S2, S2 -a-> S0.
//       a=0: hold current state.
//     While eng_enable=0: hold current state.
//     Encoding: S0=0, S1=1, S2=2. Illegal encoding 3 -> S0 on the next edge.
//     eng_y = (shadow==S1)||(shadow==S2), decoded directly from the register.
//   Simultaneous events:
//     Tick coincident with a grant pulse: eng_enable stays 1 for back-to-back steps (div=0 case).
//     The shadow advances on each step.
// TESTING
//   1 div=0, req=0001, req_a=0001 held 4 cycles after reset
//     -> gnt[0]=1 and eng_enable=1 on cycles 1..4.
//     -> shadow S0->S1->S2->S0->S1; eng_y=0,1,1,0,1 at cycles 1..5.
//   2 div=3, req=1111 held
//     -> grants in order 0,1,2,3,0 on cycles 1,5,9,13,17; gnt is 0 on all other cycles.
//   3 ptr=2 (after a grant to 1), req=0011
//     -> next tick grants 0 (wrap); the following tick grants 1.
//   4 req=0100, req_a=0000
//     -> eng_enable pulse with eng_a=0; shadow and eng_y unchanged.
//   5 reset=1 in a tick cycle with req=1111
//     -> no gnt next cycle; ptr=0, so the first post-reset grant goes to 0.
//   6 div 3->0 written mid-period
//     -> the remaining count completes at 4 cycles; ticks then occur every cycle.

Source files
------------

// File: rtl/moore_step_arbiter.sv
// Round-robin arbiter that time-shares one Moore step engine among NREQ requesters.
// A prescaler sets the step rate, and a shadow copy of the engine state drives eng_y.
module moore_step_arbiter #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_a,
  output logic [NREQ-1:0]  gnt,
  output logic             eng_enable,
  output logic             eng_a,
  output logic             eng_y
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S0    = 2'd0,
    S1    = 2'd1,
    S2    = 2'd2,
    S_BAD = 2'd3
  } state_t;

  logic [DIV_W-1:0] cnt_r;
  logic [PTR_W-1:0] ptr_r;
  state_t           state_r;
  state_t           state_s;
  logic             tick_s;
  logic             win_found_s;
  logic [PTR_W-1:0] win_idx_s;
  logic [PTR_W-1:0] ptr_next_s;
  logic [NREQ-1:0]  win_onehot_s;

  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    return PTR_W'(sum % NREQ);
  endfunction

  assign tick_s = (cnt_r == {DIV_W{1'b0}});

  // Round-robin winner search starting at ptr, plus the pointer value just past the winner.
  always_comb begin
    win_found_s  = 1'b0;
    win_idx_s    = {PTR_W{1'b0}};
    ptr_next_s   = ptr_r;
    win_onehot_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found_s && req[rr_index(ptr_r, i)]) begin
        win_found_s = 1'b1;
        win_idx_s   = rr_index(ptr_r, i);
      end else begin
        win_found_s = win_found_s;
      end
    end
    if (win_idx_s == PTR_W'(NREQ - 1)) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = win_idx_s + PTR_W'(1);
    end
    if (win_found_s) begin
      win_onehot_s = NREQ'(1) << win_idx_s;
    end else begin
      win_onehot_s = {NREQ{1'b0}};
    end
  end

  // Prescaler, pointer and registered grant/engine outputs; div is only sampled at reload.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= {DIV_W{1'b0}};
      ptr_r      <= {PTR_W{1'b0}};
      gnt        <= {NREQ{1'b0}};
      eng_enable <= 1'b0;
      eng_a      <= 1'b0;
    end else begin
      if (tick_s) begin
        cnt_r <= div;
      end else begin
        cnt_r <= cnt_r - DIV_W'(1);
      end
      if (tick_s && win_found_s) begin
        gnt        <= win_onehot_s;
        eng_enable <= 1'b1;
        eng_a      <= req_a[win_idx_s];
        ptr_r      <= ptr_next_s;
      end else begin
        gnt        <= {NREQ{1'b0}};
        eng_enable <= 1'b0;
        eng_a      <= 1'b0;
      end
    end
  end

  // Shadow state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S0;
    end else begin
      state_r <= state_s;
    end
  end

  // Shadow next state: advance only on an enabled step with a=1; the unused code recovers to S0.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S0: begin
        if (eng_enable && eng_a) begin
          state_s = S1;
        end else begin
          state_s = S0;
        end
      end
      S1: begin
        if (eng_enable && eng_a) begin
          state_s = S2;
        end else begin
          state_s = S1;
        end
      end
      S2: begin
        if (eng_enable && eng_a) begin
          state_s = S0;
        end else begin
          state_s = S2;
        end
      end
      default: state_s = S0;
    endcase
  end

  assign eng_y = (state_r == S1) || (state_r == S2);

endmodule

// File: tb/tb_moore_step_arbiter.sv
// Scoreboard bench: a cycle-level reference model predicts every grant and the shadow output,
// and an independent monitor compares what the DUT presents against the queued expectations.
module tb_moore_step_arbiter;
  localparam int NREQ  = 4;
  localparam int DIV_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [DIV_W-1:0] div   = 8'd0;
  logic [NREQ-1:0]  req   = 4'd0;
  logic [NREQ-1:0]  req_a = 4'd0;
  logic [NREQ-1:0]  gnt;
  logic             eng_enable;
  logic             eng_a;
  logic             eng_y;

  moore_step_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W)) dut (
    .clock(clock), .reset(reset), .div(div), .req(req), .req_a(req_a),
    .gnt(gnt), .eng_enable(eng_enable), .eng_a(eng_a), .eng_y(eng_y)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] gnt;
    logic            a;
    logic            y;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 1'b0;

  // Reference model: next tick cycle number, pointer, engine step count mod 3.
  int m_next_tick = 1;
  int m_ptr       = 0;
  int m_shadow    = 0;
  int last_grant  = -1;

  task automatic step(input logic r, input logic [DIV_W-1:0] d,
                      input logic [NREQ-1:0] rq, input logic [NREQ-1:0] ra);
    exp_t e;
    bit   found;
    int   k;
    @(posedge clock);
    #1;
    reset = r; div = d; req = rq; req_a = ra;
    last_grant = -1;
    if (r) begin
      m_next_tick = cyc + 1;
      m_ptr       = 0;
      m_shadow    = 0;
    end else if (cyc == m_next_tick) begin
      m_next_tick = cyc + int'(d) + 1;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (!found && rq[k]) begin
          found      = 1'b1;
          last_grant = k;
        end
      end
      if (found) begin
        m_ptr = (last_grant + 1) % NREQ;
        if (ra[last_grant]) m_shadow = (m_shadow + 1) % 3;
        e.cyc = cyc + 1;
        e.gnt = NREQ'(1 << last_grant);
        e.a   = ra[last_grant];
        e.y   = (m_shadow != 0);
        exp_q.push_back(e);
      end
    end
  endtask

  // Idle until the next cycle is a tick (bounded).
  task automatic sync_tick(input logic [DIV_W-1:0] d);
    int guard;
    guard = 0;
    while (m_next_tick != cyc + 1 && guard < 300) begin
      step(1'b0, d, 4'd0, 4'd0);
      guard++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [NREQ-1:0]  rq;
    logic [DIV_W-1:0] d;
    step(1'b1, 8'd0, 4'd0, 4'd0);
    step(1'b1, 8'd0, 4'd0, 4'd0);
    repeat (4) step(1'b0, 8'd0, 4'b0001, 4'b0001);
    repeat (3) step(1'b0, 8'd0, 4'b0000, 4'b0000);
    step(1'b0, 8'd0, 4'b0100, 4'b0000);
    repeat (2) step(1'b0, 8'd0, 4'b0000, 4'b0000);
    repeat (20) step(1'b0, 8'd3, 4'b1111, 4'b1010);
    sync_tick(8'd3);
    step(1'b0, 8'd3, 4'b0010, 4'b0010);
    repeat (8) step(1'b0, 8'd3, 4'b0011, 4'b0001);
    sync_tick(8'd3);
    step(1'b1, 8'd3, 4'b1111, 4'b1111);
    repeat (6) step(1'b0, 8'd3, 4'b1111, 4'b0000);
    sync_tick(8'd3);
    step(1'b0, 8'd3, 4'b0000, 4'b0000);
    step(1'b0, 8'd3, 4'b0000, 4'b0000);
    step(1'b0, 8'd0, 4'b0000, 4'b0000);
    repeat (8) step(1'b0, 8'd0, 4'b1111, 4'($urandom));
    rq = 4'd0;
    d  = 8'd1;
    repeat (2000) begin
      if ($urandom_range(0, 49) == 0) d = 8'($urandom_range(0, 5));
      for (int b = 0; b < NREQ; b++) begin
        if (last_grant == b && $urandom_range(0, 1) == 0) rq[b] = 1'b0;
        else if (!rq[b] && $urandom_range(0, 2) == 0) rq[b] = 1'b1;
        else if (rq[b] && $urandom_range(0, 15) == 0) rq[b] = 1'b0;
      end
      step(($urandom_range(0, 199) == 0), d, rq, 4'($urandom));
    end
    repeat (12) step(1'b0, 8'd0, 4'd0, 4'd0);
    done = 1'b1;
  end

  // Monitor: pops an expectation whenever the DUT presents a grant, checks idle cycles and eng_y.
  initial begin
    exp_t e;
    logic y_exp;
    logic y_nxt;
    y_exp = 1'b0;
    forever begin
      @(negedge clock);
      if (done) break;
      if (cyc >= 1) begin
        y_nxt = y_exp;
        if (eng_enable || gnt != 4'd0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_grant cyc=%0d got gnt=%b en=%b want no grant", cyc, gnt, eng_enable);
          end else begin
            e = exp_q.pop_front();
            chk("grant_cycle", cyc, e.cyc);
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("eng_enable", 32'(eng_enable), 32'd1);
            chk("eng_a", 32'(eng_a), 32'(e.a));
            y_nxt = e.y;
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missing_grant cyc=%0d got gnt=%b want gnt=%b", cyc, gnt, e.gnt);
          y_nxt = e.y;
        end else begin
          chk("idle_eng_a", 32'(eng_a), 32'd0);
        end
        chk("eng_y", 32'(eng_y), 32'(y_exp));
        y_exp = reset ? 1'b0 : y_nxt;
      end
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no completion want finish", cyc);
    $fatal(1);
  end

endmodule
